// File: rtl/hash_ctrl_pkg.sv
// Shared types for controllers that sequence messages through a pearson_hash8 core.
package hash_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    RUN,
    NEXT,
    RESP
  } hash_state_t;

  localparam logic [7:0] HASH_SEED = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after last_grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending at last_grant itself.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one pearson_hash8 core between NUM_REQ requesters, chaining message bytes through it.
// Optional per-byte watchdog: define HASH_ARB_TIMEOUT_EN.
module hash_core_arbiter
  import hash_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MAX_BYTES      = 4,
  parameter int unsigned LEN_W          = 3,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*8*MAX_BYTES-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [7:0]                     rsp_hash,
  output logic                           rsp_err,
  output logic                           core_reset_n,
  output logic                           core_enable,
  output logic [7:0]                     core_message,
  input  logic [7:0]                     core_hash,
  input  logic                           core_finished
);

  localparam int unsigned      ID_W    = $clog2(NUM_REQ);
  localparam int unsigned      SLOT_W  = 8 * MAX_BYTES;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  hash_state_t       state_q, state_d;
  logic [SLOT_W-1:0] data_q, slot_c;
  logic [LEN_W-1:0]  len_q, idx_q, slot_len_c, len_eff_c, idx_inc_c;
  logic [ID_W-1:0]   id_q, last_grant_q, grant_idx_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [7:0]        chain_q, rsp_hash_q, core_message_q, byte_c;
  logic              take_c, timeout_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_c),
    .grant_idx  (grant_idx_c)
  );

  assign take_c    = (state_q == IDLE) && (|req_valid);
  assign len_eff_c = (len_q > MAX_LEN) ? MAX_LEN : len_q;
  assign idx_inc_c = idx_q + LEN_W'(1);

  // Slot and length of the granted requester.
  always_comb begin
    slot_c     = '0;
    slot_len_c = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (grant_c[r]) begin
        slot_c     = req_data[r*SLOT_W +: SLOT_W];
        slot_len_c = req_len[r*LEN_W +: LEN_W];
      end
    end
  end

  // Current message byte.
  always_comb begin
    byte_c = '0;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (idx_q == LEN_W'(b)) byte_c = data_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|req_valid) state_d = LOAD;
      LOAD: state_d = (len_eff_c == '0) ? RESP : CLR;
      CLR:  state_d = RUN;
      RUN: begin
        if (core_finished)  state_d = NEXT;
        else if (timeout_c) state_d = RESP;
      end
      NEXT: state_d = (idx_inc_c == len_eff_c) ? RESP : CLR;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q         <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      id_q           <= '0;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      chain_q        <= HASH_SEED;
      rsp_hash_q     <= 8'h00;
      core_message_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_c) begin
            data_q       <= slot_c;
            len_q        <= slot_len_c;
            id_q         <= grant_idx_c;
            last_grant_q <= grant_idx_c;
            idx_q        <= '0;
            chain_q      <= HASH_SEED;
          end
        end
        LOAD: if (len_eff_c == '0) rsp_hash_q <= 8'h00;
        CLR:  core_message_q <= byte_c ^ chain_q;
        RUN: begin
          if (core_finished)  chain_q    <= core_hash;
          else if (timeout_c) rsp_hash_q <= 8'h00;
        end
        NEXT: begin
          idx_q <= idx_inc_c;
          if (idx_inc_c == len_eff_c) rsp_hash_q <= chain_q;
        end
        default: ;
      endcase
    end
  end

`ifdef HASH_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            rsp_err_q;

  // Per-byte watchdog: restarts in CLR, counts RUN cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == CLR)      wd_q <= '0;
      else if (state_q == RUN) wd_q <= wd_q + WD_W'(1);
      if (take_c)
        rsp_err_q <= 1'b0;
      else if ((state_q == RUN) && !core_finished && timeout_c)
        rsp_err_q <= 1'b1;
    end
  end

  assign timeout_c = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = rsp_err_q;
`else
  // Watchdog limit has no effect when the watchdog is not built.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign req_ready    = (reset_n && (state_q == IDLE)) ? grant_c : '0;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = id_q;
  assign rsp_hash     = rsp_hash_q;
  assign core_enable  = (state_q == RUN);
  assign core_reset_n = reset_n && (state_q != CLR);
  assign core_message = core_message_q;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Scoreboard bench for hash_core_arbiter with a behavioural stand-in for the pearson_hash8 core.
module tb_hash_core_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned MAX_BYTES = 4;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned SLOT_W    = 8 * MAX_BYTES;

  logic                          clock = 1'b0;
  logic                          reset_n = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ*SLOT_W-1:0]     req_data = '0;
  logic [NUM_REQ*LEN_W-1:0]      req_len = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsp_valid;
  logic                          rsp_ready = 1'b1;
  logic [$clog2(NUM_REQ)-1:0]    rsp_id;
  logic [7:0]                    rsp_hash;
  logic                          rsp_err;
  logic                          core_reset_n, core_enable, core_finished;
  logic [7:0]                    core_message, core_hash;

  typedef struct {
    int         id;
    logic [7:0] hash;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass = 0;
  int         clr_cnt = 0;
  int         en_cnt = 0;
  logic       en_prev = 1'b0;
  logic       core_stall = 1'b0;
  logic [3:0] core_cnt;

  hash_core_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W), .TIMEOUT_CYCLES(32)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_len(req_len), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hash(rsp_hash),
    .rsp_err(rsp_err), .core_reset_n(core_reset_n), .core_enable(core_enable),
    .core_message(core_message), .core_hash(core_hash), .core_finished(core_finished)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] core_ref(input logic [7:0] m);
    logic [7:0] h;
    h = m;
    for (int s = 0; s < 8; s++) h = {h[4:0], h[7:5]} ^ (8'h1D + 8'(s * 37));
    return h;
  endfunction

  // Core stand-in: 8-step walk after its reset, then finished with a digest of message.
  always @(posedge clock) begin
    if (!core_reset_n)                      core_cnt <= 4'd0;
    else if (core_enable && core_cnt != 8) core_cnt <= core_cnt + 4'd1;
  end
  assign core_finished = !core_stall && (core_cnt == 4'd8);
  assign core_hash     = core_finished ? core_ref(core_message) : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (reset_n && !core_reset_n) clr_cnt++;
    if (core_enable) en_cnt++;
    if (core_enable && !en_prev) begin
      if (msg_q.size() == 0) check("msg_unexpected", 1, 0);
      else check("core_message", core_message, msg_q.pop_front());
    end
    en_prev = core_enable;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_hash", rsp_hash, mon_e.hash);
        check("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic drive(input int id, input int len, input logic [SLOT_W-1:0] d, input bit to_err);
    int         n;
    logic [7:0] c;
    exp_t       e;
    n = (len > MAX_BYTES) ? MAX_BYTES : len;
    c = 8'h00;
    req_data[id*SLOT_W +: SLOT_W] = d;
    req_len[id*LEN_W +: LEN_W]    = LEN_W'(len);
    req_valid[id]                 = 1'b1;
    for (int i = 0; i < n; i++) begin
      msg_q.push_back(d[i*8 +: 8] ^ c);
      if (to_err) break;
      c = core_ref(d[i*8 +: 8] ^ c);
    end
    e.id   = id;
    e.hash = to_err ? 8'h00 : c;
    e.err  = to_err;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int id);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clock);
      if (req_ready != '0) seen = 1'b1;
    end
    check("grant", req_ready, 32'(1 << id));
    @(posedge clock);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k < 200 && !seen; k++) begin
      @(negedge clock);
      if (rsp_valid) begin seen = 1'b1; lat = k; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    for (int k = 0; k < 200 && !(rsp_valid && rsp_ready); k++) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_hash"}, rsp_hash, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_core_enable"}, core_enable, 0);
    check({tag, "_core_message"}, core_message, 0);
    check({tag, "_core_reset_n"}, core_reset_n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat, c0, e0;
    bit         saw;
    logic [7:0] snap_hash;
    logic       snap_id;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("reset");
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Single byte.
    c0 = clr_cnt;
    drive(0, 1, 32'h0000_003C, 1'b0);
    wait_grant(0);
    wait_done("single", 13, lat);
    check("single_within14", 32'(lat <= 14), 1);
    check("single_clr", clr_cnt - c0, 1);

    // Three chained bytes.
    c0 = clr_cnt;
    drive(1, 3, 32'h0033_2211, 1'b0);
    wait_grant(1);
    wait_done("chain", 35, lat);
    check("chain_clr", clr_cnt - c0, 3);

    // Zero length: no core activity.
    c0 = clr_cnt; e0 = en_cnt;
    drive(0, 0, 32'hDEAD_BEEF, 1'b0);
    wait_grant(0);
    wait_done("len0", 2, lat);
    check("len0_clr", clr_cnt - c0, 0);
    check("len0_enable", en_cnt - e0, 0);

    // Oversized length clamps to MAX_BYTES.
    c0 = clr_cnt; e0 = en_cnt;
    drive(1, 7, 32'hA5C3_7E19, 1'b0);
    wait_grant(1);
    wait_done("len7", 46, lat);
    check("len7_clr", clr_cnt - c0, 4);
    check("len7_enable", en_cnt - e0, 36);

    // Fairness from reset: 0,1,0,1.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    drive(0, 2, 32'h0000_5A01, 1'b0);
    drive(1, 2, 32'h0000_77F0, 1'b0);
    drive(0, 2, 32'h0000_5A01, 1'b0);
    drive(1, 2, 32'h0000_77F0, 1'b0);
    for (int g = 0; g < 4; g++) begin
      saw = 1'b0;
      for (int k = 0; k < 100 && !saw; k++) begin
        @(negedge clock);
        if (req_ready != '0) saw = 1'b1;
      end
      check("fair_grant", req_ready, 32'(1 << (g % 2)));
      @(posedge clock);
      #1 if (g >= 2) req_valid[g % 2] = 1'b0;
    end
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clock);
    check("fair_drain", sb.size(), 0);
    @(posedge clock);
    #1;

    // Backpressure holds the response and blocks further grants.
    rsp_ready = 1'b0;
    drive(0, 2, 32'h0000_9B42, 1'b0);
    wait_grant(0);
    for (int k = 0; k < 100 && !rsp_valid; k++) @(negedge clock);
    snap_hash = rsp_hash;
    snap_id   = rsp_id;
    drive(1, 1, 32'h0000_0013, 1'b0);
    repeat (10) begin
      @(negedge clock);
      check("bp_valid", rsp_valid, 1);
      check("bp_hash", rsp_hash, snap_hash);
      check("bp_id", rsp_id, snap_id);
      check("bp_no_grant", req_ready, 0);
    end
    @(posedge clock);
    #1 rsp_ready = 1'b1;
    wait_grant(1);
    wait_done("bp_next", 13, lat);

    // Reset during RUN discards the request.
    core_stall = 1'b1;
    drive(0, 2, 32'h0000_6655, 1'b0);
    wait_grant(0);
    for (int k = 0; k < 50 && !core_enable; k++) @(negedge clock);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    sb.delete();
    msg_q.delete();
    @(posedge clock);
    @(negedge clock);
    check_reset_vals("midrun");
    core_stall = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (rsp_valid) saw = 1'b1;
    end
    check("midrun_no_rsp", saw, 0);
    @(posedge clock);
    #1;
    drive(0, 1, 32'h0000_0081, 1'b0);
    drive(1, 2, 32'h0000_C2C1, 1'b0);
    wait_grant(0);
    wait_done("post_rst0", 13, lat);
    wait_grant(1);
    wait_done("post_rst1", 24, lat);

`ifdef HASH_ARB_TIMEOUT_EN
    // Stalled core trips the watchdog on the first byte.
    core_stall = 1'b1;
    drive(0, 3, 32'h0030_2010, 1'b1);
    wait_grant(0);
    wait_done("watchdog", 35, lat);
    core_stall = 1'b0;
    drive(1, 1, 32'h0000_0044, 1'b0);
    wait_grant(1);
    wait_done("wd_clear", 13, lat);
`endif

    repeat (5) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    check("msg_empty", msg_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
